// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// Each instruction is walked through IF/ID/EX/MEM/WB over several clocks.
// The FSM drives the same datapath selects as the single-cycle decoder,
// plus the PC/IR write enables, and waits on a data-memory ready handshake.
module multicycle_ctrl #(
    parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Z,
    input  logic       Mrdy,
    output logic       Irwrite,
    output logic       Pcwrite,
    output logic [1:0] PCsrc,
    output logic       Regrt,
    output logic       Se,
    output logic       Aluqb,
    output logic [1:0] Aluc,
    output logic       Wreg,
    output logic       Wmem,
    output logic       Reg2reg,
    output logic [2:0] State,
    output logic       Illegal,
    output logic       Timeout
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_waitCnt;
    logic       r_illegal;
    logic       r_timeout;

    logic       w_isR, w_rFuncOk, w_isAddi, w_isAndi, w_isOri;
    logic       w_isLw, w_isSw, w_isBeq, w_isBne, w_isJ, w_legal;
    logic       w_memExpired, w_branchTaken, w_holdSelects;
    logic [1:0] w_instAluc;
    logic       w_instAluqb, w_instSe;

    logic       w_irwrite, w_pcwrite, w_wreg, w_wmem;
    logic [1:0] w_pcsrc, w_aluc;
    logic       w_regrt, w_se, w_aluqb, w_reg2reg;
    logic       w_setIllegal, w_setTimeout;

    assign w_isR     = (Op == OP_RTYPE);
    assign w_rFuncOk = (Func == FN_ADD) || (Func == FN_SUB) ||
                       (Func == FN_AND) || (Func == FN_OR);
    assign w_isAddi  = (Op == OP_ADDI);
    assign w_isAndi  = (Op == OP_ANDI);
    assign w_isOri   = (Op == OP_ORI);
    assign w_isLw    = (Op == OP_LW);
    assign w_isSw    = (Op == OP_SW);
    assign w_isBeq   = (Op == OP_BEQ);
    assign w_isBne   = (Op == OP_BNE);
    assign w_isJ     = (Op == OP_J);
    assign w_legal   = (w_isR && w_rFuncOk) || w_isAddi || w_isAndi || w_isOri ||
                       w_isLw || w_isSw || w_isBeq || w_isBne || w_isJ;

    // The abort fires on the last permitted MEM cycle, so MEM lasts exactly MEM_TIMEOUT cycles.
    assign w_memExpired  = (r_waitCnt == (MEM_TIMEOUT - 4'd1));
    assign w_branchTaken = (w_isBeq && Z) || (w_isBne && !Z);
    assign w_holdSelects = (r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB);

    // ALU operand/operation selects for the instruction held in the IR.
    always_comb begin
        w_instAluc  = 2'b00;
        w_instAluqb = 1'b0;
        w_instSe    = 1'b0;
        if (w_isR) begin
            case (Func)
                FN_SUB:  w_instAluc = 2'b01;
                FN_AND:  w_instAluc = 2'b10;
                FN_OR:   w_instAluc = 2'b11;
                default: w_instAluc = 2'b00;
            endcase
        end else if (w_isAddi || w_isLw || w_isSw) begin
            w_instAluqb = 1'b1;
            w_instSe    = 1'b1;
        end else if (w_isAndi || w_isOri) begin
            w_instAluqb = 1'b1;
            w_instAluc  = w_isOri ? 2'b11 : 2'b10;
        end else if (w_isBeq || w_isBne) begin
            w_instAluc  = 2'b01;
            w_instSe    = 1'b1;
        end
    end

    // Next-state and raw output decode from the registered state.
    always_comb begin
        w_nextState  = r_state;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_pcsrc      = 2'b00;
        w_regrt      = 1'b0;
        w_se         = 1'b0;
        w_aluqb      = 1'b0;
        w_aluc       = 2'b00;
        w_wreg       = 1'b0;
        w_wmem       = 1'b0;
        w_reg2reg    = 1'b0;
        w_setIllegal = 1'b0;
        w_setTimeout = 1'b0;
        if (w_holdSelects) begin
            w_aluc  = w_instAluc;
            w_aluqb = w_instAluqb;
            w_se    = w_instSe;
        end
        case (r_state)
            S_IF: begin
                w_irwrite   = 1'b1;
                w_nextState = S_ID;
            end
            S_ID: begin
                if (!w_legal) begin
                    w_setIllegal = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_nextState  = S_IF;
                end else if (w_isJ) begin
                    w_pcwrite   = 1'b1;
                    w_pcsrc     = 2'b10;
                    w_nextState = S_IF;
                end else begin
                    w_nextState = S_EX;
                end
            end
            S_EX: begin
                if (w_isBeq || w_isBne) begin
                    w_pcwrite   = 1'b1;
                    w_pcsrc     = w_branchTaken ? 2'b01 : 2'b00;
                    w_nextState = S_IF;
                end else if (w_isLw || w_isSw) begin
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_WB;
                end
            end
            S_MEM: begin
                if (Mrdy) begin
                    if (w_isSw) begin
                        w_wmem      = 1'b1;
                        w_pcwrite   = 1'b1;
                        w_nextState = S_IF;
                    end else begin
                        w_nextState = S_WB;
                    end
                end else if (w_memExpired) begin
                    w_setTimeout = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_nextState  = S_IF;
                end
            end
            S_WB: begin
                w_wreg      = 1'b1;
                w_pcwrite   = 1'b1;
                w_regrt     = !w_isR;
                w_reg2reg   = w_isLw;
                w_nextState = S_IF;
            end
            default: w_nextState = S_IF;
        endcase
    end

    // State register; reset always returns to instruction fetch.
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_IF;
        else     r_state <= w_nextState;
    end

    // MEM wait counter; zero outside MEM so every memory access starts fresh.
    always_ff @(posedge Clk) begin
        if (Rst)                               r_waitCnt <= 4'd0;
        else if (r_state == S_MEM && !Mrdy)    r_waitCnt <= r_waitCnt + 4'd1;
        else                                   r_waitCnt <= 4'd0;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_setIllegal) r_illegal <= 1'b1;
            if (w_setTimeout) r_timeout <= 1'b1;
        end
    end

    // Enables are masked during reset so no write escapes while aborting an instruction.
    assign Irwrite = w_irwrite & ~Rst;
    assign Pcwrite = w_pcwrite & ~Rst;
    assign Wreg    = w_wreg & ~Rst;
    assign Wmem    = w_wmem & ~Rst;
    assign PCsrc   = w_pcsrc;
    assign Regrt   = w_regrt;
    assign Se      = w_se;
    assign Aluqb   = w_aluqb;
    assign Aluc    = w_aluc;
    assign Reg2reg = w_reg2reg;
    assign State   = r_state;
    assign Illegal = r_illegal;
    assign Timeout = r_timeout;

endmodule
